param_buffer_ctrl: RTL and testbench
====================================

// Module: param_buffer_ctrl
// PURPOSE
//  Sequencer for the 64-lane parameter buffer (4 x 16-lane MLB banks).
//  Fills the buffer from the weight DMA with a valid/ready handshake, then streams it to the PE array.
//  Drives the buffer's write enable, read enable, sub-tile index and unit-tile index.
//  A stream walks every sub tile; within each sub tile it walks every unit tile (one per PE column).
//  A loaded tile can be replayed cfg_passes times without a reload.
// PARAMETERS
//  NUM_SUB     4  sub tiles per tile (range of sub_tile_idx)
//  NUM_UNIT    8  unit tiles per sub tile, equal to the PE column count (range of unit_tile_idx)
//  RD_LAT      1  buffer read latency in cycles, from par_read_en to valid out[]
//  PASS_W      4  width of cfg_passes
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous active-high reset
//  start_load     in   1       pulse; accepted only in IDLE or FULL
//  wr_valid       in   1       DMA beat valid; data goes directly to the buffer in[]
//  wr_ready       out  1       beat accepted when wr_valid & wr_ready
//  start_stream   in   1       pulse; accepted only in FULL
//  cfg_passes     in   PASS_W  replay count, sampled at start_stream; 0 is treated as 1
//  pe_ready       in   1       PE array can take one unit tile this cycle
//  par_write_en   out  1       to buffer
//  par_read_en    out  1       to buffer
//  sub_tile_idx   out  2       to buffer
//  unit_tile_idx  out  3       to buffer; also the PE column select
//  out_valid      out  1       buffer out[] is valid for PE column col_idx
//  col_idx        out  3       unit_tile_idx delayed by RD_LAT cycles
//  busy           out  1       state is not IDLE and not FULL
//  done           out  1       one-cycle pulse when the final pass completes
// BEHAVIOUR
//  Reset: state=IDLE. Every output is 0. All counters are 0. Reset mid-operation aborts immediately;
//   the buffer contents are then undefined and FULL is not re-entered.
//  States: IDLE -> LOAD -> FULL -> STREAM -> DRAIN -> FULL.
//  IDLE: start_load -> LOAD. Other inputs are ignored.
//  LOAD: wr_ready=1. par_write_en = wr_valid & wr_ready (combinational).
//   Indices are registered counters, unit-tile inner and sub-tile outer.
//   Each handshake advances the indices. The NUM_SUB*NUM_UNIT-th handshake moves to FULL next cycle.
//   wr_valid=0 stalls; the indices hold.
//  FULL: wr_ready=0. start_load -> LOAD with counters cleared (reload).
//   start_stream -> STREAM with the pass counter loaded. If both are high in one cycle, start_load wins.
//  STREAM: par_read_en = pe_ready (combinational). The index sweep is the same as LOAD, gated by pe_ready.
//   After the last beat: if passes remain, decrement, clear the indices and stay in STREAM
//   (no bubble between passes); otherwise go to DRAIN.
//  DRAIN: wait RD_LAT cycles for the final out_valid, then pulse done and go to FULL.
//  out_valid/col_idx: par_read_en/unit_tile_idx delayed through an RD_LAT-deep shift register;
//   cleared on rst.
//  start_* pulses outside their legal state are dropped and have no side effects.
//  Index counters wrap modulo NUM_UNIT and NUM_SUB. Counter widths are $clog2 of each.
// CONFIGURATION
//  PBC_PERF_CNT_EN defined:
//   - Adds stall_cnt [31:0]: cycles in LOAD with wr_valid=0 plus cycles in STREAM with pe_ready=0.
//   - Adds beat_cnt [31:0]: read beats issued.
//   - Both saturate, clear on rst, and clear on start_load.
//  Not defined: these ports and counters are absent. Other behaviour is identical.
// STRUCTURE
//  Shared package acc_pkg: pbc_state_e enum (IDLE, LOAD, FULL, STREAM, DRAIN),
//   SUB_IDX_W=2, UNIT_IDX_W=3, TILE_BEATS = NUM_SUB*NUM_UNIT.
//  Sub-module tile_idx_cnt: nested unit/sub counter with clr, adv and last outputs.
//   One instance serves both LOAD and STREAM.
// TESTING
//  Reset, then start_load with wr_valid held high: 32 write beats with idx (0,0),(0,1)..(3,7); FULL on the cycle after beat 32.
//  LOAD with wr_valid toggled 1,0,1,0: indices advance only on handshakes; total beats still 32.
//  start_stream with cfg_passes=2 and pe_ready=1: 64 contiguous reads; done one cycle after DRAIN's RD_LAT cycles; back in FULL.
//  STREAM with pe_ready low for 3 cycles at idx (2,5): par_read_en=0 and idx held; resumes at (2,5).
//  start_stream in IDLE or LOAD: ignored. start_load plus start_stream in FULL: LOAD is entered.
//  rst asserted mid-STREAM at (1,3): next cycle IDLE, all outputs 0, out_valid 0.

Source files
------------

// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
//   Shared types and constants for the parameter-buffer sequencer.
//   - pbc_state_e : sequencer state encoding
//   - NUM_SUB / NUM_UNIT : default tile geometry (4 sub tiles x 8 unit tiles)
//   - SUB_IDX_W / UNIT_IDX_W : index widths driven to the buffer
//   - TILE_BEATS : beats needed to fill or sweep one tile
//   - sat_inc32() : saturating 32-bit increment used by the optional
//     performance counters
// -----------------------------------------------------------------------------
package acc_pkg;

  localparam int NUM_SUB    = 4;
  localparam int NUM_UNIT   = 8;
  localparam int SUB_IDX_W  = $clog2(NUM_SUB);
  localparam int UNIT_IDX_W = $clog2(NUM_UNIT);
  localparam int TILE_BEATS = NUM_SUB * NUM_UNIT;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    FULL   = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4
  } pbc_state_e;

  // Holds at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/tile_idx_cnt.sv
// -----------------------------------------------------------------------------
// tile_idx_cnt
//   Nested tile index counter: unit-tile index is the inner digit, sub-tile
//   index the outer digit. Shared by the fill (LOAD) and read (STREAM) sweeps.
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   clr        in   clear both indices to 0 (wins over adv)
//   adv        in   advance one beat; wraps modulo NUM_UNIT / NUM_SUB
//   sub_idx_o  out  current sub-tile index
//   unit_idx_o out  current unit-tile index
//   last_o     out  current position is the final beat of the tile
// -----------------------------------------------------------------------------
module tile_idx_cnt
  import acc_pkg::*;
#(
  parameter int NUM_SUB  = acc_pkg::NUM_SUB,
  parameter int NUM_UNIT = acc_pkg::NUM_UNIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  adv,
  output logic [SUB_IDX_W-1:0]  sub_idx_o,
  output logic [UNIT_IDX_W-1:0] unit_idx_o,
  output logic                  last_o
);

  localparam logic [SUB_IDX_W-1:0]  SUB_MAX  = SUB_IDX_W'(NUM_SUB - 1);
  localparam logic [UNIT_IDX_W-1:0] UNIT_MAX = UNIT_IDX_W'(NUM_UNIT - 1);

  logic [SUB_IDX_W-1:0]  sub_q;
  logic [UNIT_IDX_W-1:0] unit_q;
  logic                  sub_last;
  logic                  unit_last;

  assign sub_last  = (sub_q == SUB_MAX);
  assign unit_last = (unit_q == UNIT_MAX);

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sub_q  <= '0;
      unit_q <= '0;
    end else if (adv) begin
      if (unit_last) begin
        unit_q <= '0;
        sub_q  <= sub_last ? '0 : sub_q + SUB_IDX_W'(1);
      end else begin
        unit_q <= unit_q + UNIT_IDX_W'(1);
      end
    end
  end

  assign sub_idx_o  = sub_q;
  assign unit_idx_o = unit_q;
  assign last_o     = sub_last && unit_last;

endmodule

// File: rtl/param_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// param_buffer_ctrl
//   Sequencer for the 64-lane parameter buffer (4 x 16-lane MLB banks).
//   Fills the buffer from the weight DMA (valid/ready), then streams the tile
//   to the PE array, sub tile by sub tile and unit tile (PE column) by unit
//   tile. A loaded tile may be replayed cfg_passes times without reloading.
//
// Configuration macro
//   PBC_PERF_CNT_EN : adds stall_cnt / beat_cnt saturating counters and ports.
//
// Ports
//   clk            in   clock
//   rst            in   synchronous active-high reset (aborts any operation)
//   start_load     in   pulse, honoured in IDLE or FULL
//   wr_valid       in   DMA beat valid
//   wr_ready       out  high in LOAD
//   start_stream   in   pulse, honoured in FULL only
//   cfg_passes     in   replay count sampled at start_stream (0 acts as 1)
//   pe_ready       in   PE array accepts one unit tile this cycle
//   par_write_en   out  buffer write enable (wr_valid & wr_ready)
//   par_read_en    out  buffer read enable (pe_ready while streaming)
//   sub_tile_idx   out  buffer sub-tile index
//   unit_tile_idx  out  buffer unit-tile index / PE column select
//   out_valid      out  buffer out[] valid for column col_idx
//   col_idx        out  unit_tile_idx delayed by RD_LAT
//   busy           out  state is LOAD, STREAM or DRAIN
//   done           out  one-cycle pulse after the final pass has drained
//   stall_cnt      out  (PBC_PERF_CNT_EN) stalled LOAD/STREAM cycles
//   beat_cnt       out  (PBC_PERF_CNT_EN) read beats issued
// -----------------------------------------------------------------------------
module param_buffer_ctrl
  import acc_pkg::*;
#(
  parameter int NUM_SUB  = acc_pkg::NUM_SUB,
  parameter int NUM_UNIT = acc_pkg::NUM_UNIT,
  parameter int RD_LAT   = 1,
  parameter int PASS_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_load,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  start_stream,
  input  logic [PASS_W-1:0]     cfg_passes,
  input  logic                  pe_ready,
  output logic                  par_write_en,
  output logic                  par_read_en,
  output logic [SUB_IDX_W-1:0]  sub_tile_idx,
  output logic [UNIT_IDX_W-1:0] unit_tile_idx,
  output logic                  out_valid,
  output logic [UNIT_IDX_W-1:0] col_idx,
  output logic                  busy,
  output logic                  done
`ifdef PBC_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           beat_cnt
`endif
);

  localparam int DRAIN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  pbc_state_e state_q, state_d;

  logic [PASS_W-1:0]  pass_q;
  logic [DRAIN_W-1:0] drain_q;
  logic               drain_last;
  logic               done_q;
  logic               more_passes;

  logic cnt_clr, cnt_adv, cnt_last;
  logic pass_load, pass_dec;

  // ---------------------------------------------------------------------------
  // Shared index counter (fill sweep and read sweep)
  // ---------------------------------------------------------------------------
  tile_idx_cnt #(
    .NUM_SUB  (NUM_SUB),
    .NUM_UNIT (NUM_UNIT)
  ) u_idx (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr),
    .adv        (cnt_adv),
    .sub_idx_o  (sub_tile_idx),
    .unit_idx_o (unit_tile_idx),
    .last_o     (cnt_last)
  );

  assign more_passes = (pass_q > PASS_W'(1));
  assign drain_last  = (drain_q == DRAIN_W'(RD_LAT - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start_load) state_d = LOAD;
      LOAD:   if (wr_valid && cnt_last) state_d = FULL;
      // Reload takes priority over streaming when both pulses coincide.
      FULL: begin
        if (start_load)        state_d = LOAD;
        else if (start_stream) state_d = STREAM;
      end
      STREAM: if (pe_ready && cnt_last && !more_passes) state_d = DRAIN;
      DRAIN:  if (drain_last) state_d = FULL;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ready     = 1'b0;
    par_write_en = 1'b0;
    par_read_en  = 1'b0;
    cnt_clr      = 1'b0;
    cnt_adv      = 1'b0;
    pass_load    = 1'b0;
    pass_dec     = 1'b0;
    unique case (state_q)
      IDLE: cnt_clr = start_load;
      LOAD: begin
        wr_ready     = 1'b1;
        par_write_en = wr_valid;
        cnt_adv      = wr_valid;
      end
      FULL: begin
        cnt_clr   = start_load || start_stream;
        pass_load = start_stream && !start_load;
      end
      STREAM: begin
        par_read_en = pe_ready;
        cnt_adv     = pe_ready;
        // The index counter wraps to (0,0) on the last beat, so a further
        // pass starts on the very next cycle without a bubble.
        pass_dec    = pe_ready && cnt_last && more_passes;
      end
      default: ;
    endcase
  end

  assign busy = (state_q == LOAD) || (state_q == STREAM) || (state_q == DRAIN);

  // ---------------------------------------------------------------------------
  // Pass counter, drain timer, done pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= '0;
    end else if (pass_load) begin
      pass_q <= (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
    end else if (pass_dec) begin
      pass_q <= pass_q - PASS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state_q != DRAIN) drain_q <= '0;
    else if (!drain_last)        drain_q <= drain_q + DRAIN_W'(1);
  end

  // Registered so the pulse lands on the first FULL cycle after DRAIN.
  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= (state_q == DRAIN) && drain_last;
  end

  assign done = done_q;

  // ---------------------------------------------------------------------------
  // Read-latency alignment: out_valid / col_idx follow the buffer's output
  // ---------------------------------------------------------------------------
  logic [RD_LAT-1:0]                 vld_pipe_q;
  logic [RD_LAT-1:0][UNIT_IDX_W-1:0] col_pipe_q;

  // NOTE: this shift register is reset (unlike a pure data array) because
  // out_valid and col_idx must read 0 immediately after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      col_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= par_read_en;
      col_pipe_q[0] <= unit_tile_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        col_pipe_q[i] <= col_pipe_q[i-1];
      end
    end
  end

  assign out_valid = vld_pipe_q[RD_LAT-1];
  assign col_idx   = col_pipe_q[RD_LAT-1];

`ifdef PBC_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Optional performance counters (saturating, cleared by an accepted load)
  // ---------------------------------------------------------------------------
  logic [31:0] stall_cnt_q, beat_cnt_q;
  logic        perf_clr, stall_evt;

  assign perf_clr  = start_load && ((state_q == IDLE) || (state_q == FULL));
  assign stall_evt = ((state_q == LOAD) && !wr_valid) ||
                     ((state_q == STREAM) && !pe_ready);

  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      stall_cnt_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      if (stall_evt)   stall_cnt_q <= sat_inc32(stall_cnt_q);
      if (par_read_en) beat_cnt_q  <= sat_inc32(beat_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign beat_cnt  = beat_cnt_q;
`endif

endmodule

// File: tb/tb_param_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_param_buffer_ctrl
//   Directed bench for param_buffer_ctrl (default build). Inputs change 1
//   time unit after each rising edge, outputs are sampled 1 unit later.
// -----------------------------------------------------------------------------
module tb_param_buffer_ctrl;
  import acc_pkg::*;

  localparam int PASS_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_load = 1'b0;
  logic              wr_valid = 1'b0;
  logic              start_stream = 1'b0;
  logic              pe_ready = 1'b0;
  logic [PASS_W-1:0] cfg_passes = '0;
  logic              wr_ready, par_write_en, par_read_en;
  logic              out_valid, busy, done;
  logic [1:0]        sub_tile_idx;
  logic [2:0]        unit_tile_idx, col_idx;

  int n_checks = 0;
  int n_pass   = 0;

  param_buffer_ctrl #(.RD_LAT(1), .PASS_W(PASS_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_load    (start_load),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .start_stream  (start_stream),
    .cfg_passes    (cfg_passes),
    .pe_ready      (pe_ready),
    .par_write_en  (par_write_en),
    .par_read_en   (par_read_en),
    .sub_tile_idx  (sub_tile_idx),
    .unit_tile_idx (unit_tile_idx),
    .out_valid     (out_valid),
    .col_idx       (col_idx),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // All outputs packed for whole-port comparisons.
  logic [13:0] outs;
  assign outs = {wr_ready, par_write_en, par_read_en, sub_tile_idx,
                 unit_tile_idx, out_valid, col_idx, busy, done};

  logic [2:0] st;
  assign st = dut.state_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    #1;
    n_checks++;
    if (outs !== 14'h0) $display("FAIL reset_outs: got %h expected %h", outs, 14'h0);
    else n_pass++;
    rst = 1'b0;
    tick();
    #1;
    n_checks++;
    if (st !== 3'(IDLE)) $display("FAIL reset_state: got %0d expected %0d", st, IDLE);
    else n_pass++;
    n_checks++;
    if (outs !== 14'h0) $display("FAIL reset_release_outs: got %h expected %h", outs, 14'h0);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_load_full();
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    wr_valid   = 1'b1;
    for (int k = 0; k < TILE_BEATS; k++) begin
      #1;
      n_checks++;
      if ({wr_ready, busy, par_write_en, sub_tile_idx, unit_tile_idx} !==
          {1'b1, 1'b1, 1'b1, 2'(k / 8), 3'(k % 8)})
        $display("FAIL load_beat%0d: got we=%b idx=(%0d,%0d) expected we=1 idx=(%0d,%0d)",
                 k, par_write_en, sub_tile_idx, unit_tile_idx, k / 8, k % 8);
      else n_pass++;
      tick();
    end
    wr_valid = 1'b0;
    #1;
    n_checks++;
    if (st !== 3'(FULL)) $display("FAIL load_full_state: got %0d expected %0d", st, FULL);
    else n_pass++;
    n_checks++;
    if ({wr_ready, busy, par_write_en} !== 3'b000)
      $display("FAIL load_full_outs: got %b expected 000", {wr_ready, busy, par_write_en});
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_load_stall();
    int beats = 0;
    int c     = 0;
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    while (beats < TILE_BEATS && c < 200) begin
      wr_valid = (c % 2 == 0);
      #1;
      n_checks++;
      if ({par_write_en, sub_tile_idx, unit_tile_idx} !==
          {wr_valid, 2'(beats / 8), 3'(beats % 8)})
        $display("FAIL load_stall_c%0d: got we=%b idx=(%0d,%0d) expected we=%b idx=(%0d,%0d)",
                 c, par_write_en, sub_tile_idx, unit_tile_idx, wr_valid, beats / 8, beats % 8);
      else n_pass++;
      tick();
      if (wr_valid) beats++;
      c++;
    end
    wr_valid = 1'b0;
    #1;
    n_checks++;
    if (c !== 63) $display("FAIL load_stall_cycles: got %0d expected 63", c);
    else n_pass++;
    n_checks++;
    if (st !== 3'(FULL)) $display("FAIL load_stall_state: got %0d expected %0d", st, FULL);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stream_passes();
    cfg_passes   = 4'd2;
    pe_ready     = 1'b1;
    start_stream = 1'b1;
    tick();
    start_stream = 1'b0;
    for (int k = 0; k < 2 * TILE_BEATS; k++) begin
      #1;
      n_checks++;
      if ({par_read_en, busy, sub_tile_idx, unit_tile_idx} !==
          {1'b1, 1'b1, 2'((k % 32) / 8), 3'(k % 8)})
        $display("FAIL stream_beat%0d: got re=%b idx=(%0d,%0d) expected re=1 idx=(%0d,%0d)",
                 k, par_read_en, sub_tile_idx, unit_tile_idx, (k % 32) / 8, k % 8);
      else n_pass++;
      n_checks++;
      if ({out_valid, col_idx} !== {(k > 0), (k > 0) ? 3'((k - 1) % 8) : 3'd0})
        $display("FAIL stream_ov%0d: got ov=%b col=%0d expected ov=%b col=%0d",
                 k, out_valid, col_idx, k > 0, (k > 0) ? (k - 1) % 8 : 0);
      else n_pass++;
      tick();
    end
    #1;
    n_checks++;
    if (st !== 3'(DRAIN)) $display("FAIL drain_state: got %0d expected %0d", st, DRAIN);
    else n_pass++;
    n_checks++;
    if ({par_read_en, out_valid, col_idx, busy, done} !== 7'b0_1_111_1_0)
      $display("FAIL drain_outs: got %b expected 0111110",
               {par_read_en, out_valid, col_idx, busy, done});
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if ({st, done, out_valid, busy} !== {3'(FULL), 3'b100})
      $display("FAIL done_pulse: got st=%0d done=%b ov=%b busy=%b expected st=%0d done=1 ov=0 busy=0",
               st, done, out_valid, busy, FULL);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if (done !== 1'b0) $display("FAIL done_width: got %b expected 0", done);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stream_stall();
    int k     = 0;
    int stall = 3;
    int c     = 0;
    cfg_passes   = 4'd0;
    start_stream = 1'b1;
    tick();
    start_stream = 1'b0;
    while (k < TILE_BEATS && c < 100) begin
      pe_ready = !(k == 21 && stall > 0);
      #1;
      n_checks++;
      if ({par_read_en, sub_tile_idx, unit_tile_idx} !== {pe_ready, 2'(k / 8), 3'(k % 8)})
        $display("FAIL stall_c%0d: got re=%b idx=(%0d,%0d) expected re=%b idx=(%0d,%0d)",
                 c, par_read_en, sub_tile_idx, unit_tile_idx, pe_ready, k / 8, k % 8);
      else n_pass++;
      tick();
      if (pe_ready) k++;
      else stall--;
      c++;
    end
    pe_ready = 1'b1;
    #1;
    n_checks++;
    if (c !== 35) $display("FAIL stall_cycles: got %0d expected 35", c);
    else n_pass++;
    n_checks++;
    if (st !== 3'(DRAIN)) $display("FAIL stall_zero_pass: got %0d expected %0d", st, DRAIN);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if ({st, done} !== {3'(FULL), 1'b1})
      $display("FAIL stall_done: got st=%0d done=%b expected st=%0d done=1", st, done, FULL);
    else n_pass++;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_both_start();
    start_load   = 1'b1;
    start_stream = 1'b1;
    cfg_passes   = 4'd3;
    tick();
    start_load   = 1'b0;
    start_stream = 1'b0;
    #1;
    n_checks++;
    if ({st, wr_ready, par_read_en, sub_tile_idx, unit_tile_idx} !== {3'(LOAD), 1'b1, 1'b0, 5'd0})
      $display("FAIL both_start: got st=%0d wr_ready=%b re=%b expected st=%0d wr_ready=1 re=0",
               st, wr_ready, par_read_en, LOAD);
    else n_pass++;
    wr_valid = 1'b1;
    repeat (TILE_BEATS) tick();
    wr_valid = 1'b0;
    #1;
    n_checks++;
    if (st !== 3'(FULL)) $display("FAIL both_reload_full: got %0d expected %0d", st, FULL);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ignored();
    rst = 1'b1;
    tick();
    rst          = 1'b0;
    pe_ready     = 1'b1;
    cfg_passes   = 4'd1;
    start_stream = 1'b1;
    tick();
    start_stream = 1'b0;
    #1;
    n_checks++;
    if ({st, busy, par_read_en} !== {3'(IDLE), 2'b00})
      $display("FAIL ign_idle: got st=%0d busy=%b re=%b expected st=%0d busy=0 re=0",
               st, busy, par_read_en, IDLE);
    else n_pass++;
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    wr_valid   = 1'b1;
    repeat (5) tick();
    wr_valid     = 1'b0;
    start_stream = 1'b1;
    tick();
    start_stream = 1'b0;
    #1;
    n_checks++;
    if ({st, par_read_en, sub_tile_idx, unit_tile_idx} !== {3'(LOAD), 1'b0, 2'd0, 3'd5})
      $display("FAIL ign_load: got st=%0d re=%b idx=(%0d,%0d) expected st=%0d re=0 idx=(0,5)",
               st, par_read_en, sub_tile_idx, unit_tile_idx, LOAD);
    else n_pass++;
    wr_valid = 1'b1;
    repeat (TILE_BEATS - 5) tick();
    wr_valid = 1'b0;
    #1;
    n_checks++;
    if (st !== 3'(FULL)) $display("FAIL ign_full: got %0d expected %0d", st, FULL);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_stream();
    cfg_passes   = 4'd1;
    pe_ready     = 1'b1;
    start_stream = 1'b1;
    tick();
    start_stream = 1'b0;
    repeat (11) tick();
    #1;
    n_checks++;
    if ({st, par_read_en, sub_tile_idx, unit_tile_idx} !== {3'(STREAM), 1'b1, 2'd1, 3'd3})
      $display("FAIL mid_pos: got st=%0d re=%b idx=(%0d,%0d) expected st=%0d re=1 idx=(1,3)",
               st, par_read_en, sub_tile_idx, unit_tile_idx, STREAM);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (st !== 3'(IDLE)) $display("FAIL mid_rst_state: got %0d expected %0d", st, IDLE);
    else n_pass++;
    n_checks++;
    if (outs !== 14'h0) $display("FAIL mid_rst_outs: got %h expected %h", outs, 14'h0);
    else n_pass++;
    start_stream = 1'b1;
    tick();
    start_stream = 1'b0;
    #1;
    n_checks++;
    if (st !== 3'(IDLE)) $display("FAIL mid_no_full: got %0d expected %0d", st, IDLE);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_load_full();
    test_load_stall();
    test_stream_passes();
    test_stream_stall();
    test_both_start();
    test_ignored();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
